// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and modulo-NQ pointer helper for FIFO drain arbitration
package fifo_arb_pkg;
    localparam int QWID_DEF = 1;

    typedef logic [QWID_DEF-1:0] qid_t;

    // Wrap is explicit so NQ does not have to be a power of two.
    function automatic int qid_next(input int last, input int nq);
        return (last >= nq - 1) ? 0 : last + 1;
    endfunction
endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// rtl/fifo_drain_arbiter_if.sv - FIFO-head inputs, pop strobes and registered output stream
interface fifo_drain_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NQ    = 2,
    parameter int QWID  = 1
);
    logic                  enable;
    logic [NQ-1:0]         empty;
    logic [NQ*WIDTH-1:0]   fifo_data;
    logic [NQ-1:0]         pop;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [QWID-1:0]       out_qid;
    logic                  drained;

    modport master (
        input  enable, empty, fifo_data, out_ready,
        output pop, out_valid, out_data, out_qid, drained
    );

    modport slave (
        output enable, empty, fifo_data, out_ready,
        input  pop, out_valid, out_data, out_qid, drained
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot or zero grant
module rr_arbiter #(
    parameter int NQ   = 2,
    parameter int QWID = $clog2(NQ)
) (
    input  logic [NQ-1:0]   req_i,
    input  logic [QWID-1:0] last_i,
    output logic [NQ-1:0]   grant_o
);
    import fifo_arb_pkg::*;

    logic found;
    int   idx;

    // Scan last+1, last+2, ... and keep only the first requester.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = int'(last_i);
        for (int k = 0; k < NQ; k++) begin
            idx = qid_next(idx, NQ);
            for (int i = 0; i < NQ; i++) begin
                if (!found && req_i[i] && (i == idx)) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - drains NQ FIFOs round-robin into one registered ready/valid stream
module fifo_drain_arbiter #(
    parameter int WIDTH = 8,
    parameter int NQ    = 2,
    parameter int QWID  = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fifo_drain_arbiter_if.master bus
);
    import fifo_arb_pkg::*;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [QWID-1:0]   out_qid_q;
    logic [QWID-1:0]   last_q;
    logic [NQ-1:0]     req;
    logic [NQ-1:0]     grant;
    logic [NQ-1:0]     pop;
    logic [QWID-1:0]   gnt_idx;
    logic [WIDTH-1:0]  gnt_data;
    logic              accept;
    logic              can_load;
    logic              has_grant;

    assign accept   = bus.out_ready & out_valid_q;
    assign can_load = !out_valid_q | accept;
    assign req      = (bus.enable & can_load) ? ~bus.empty : '0;

    rr_arbiter #(.NQ(NQ), .QWID(QWID)) u_rr (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Reset masks the pop strobes combinationally so no FIFO is popped while held in reset.
    assign pop       = rst_ni ? grant : '0;
    assign has_grant = |pop;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NQ; i++) begin
            if (pop[i]) begin
                gnt_idx  = QWID'(i);
                gnt_data = bus.fifo_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_qid_q   <= '0;
            last_q      <= QWID'(NQ - 1);
        end else if (has_grant) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_qid_q   <= gnt_idx;
            last_q      <= gnt_idx;
        end else if (accept) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.pop       = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_qid   = out_qid_q;
    assign bus.drained   = (&bus.empty) & !out_valid_q;

`ifdef FORMAL
    always_comb begin
        assert ($onehot0(pop));
        for (int i = 0; i < NQ; i++) assert (!(pop[i] & bus.empty[i]));
    end

    always @(posedge clk_i) begin
        if (rst_ni && $past(rst_ni) && $past(out_valid_q) && !$past(bus.out_ready)) begin
            assert (out_valid_q && out_data_q == $past(out_data_q) && out_qid_q == $past(out_qid_q));
        end
    end
`endif
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - directed vector bench for fifo_drain_arbiter (NQ=2 and NQ=3)
module tb_fifo_drain_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fifo_drain_arbiter_if #(.WIDTH(8), .NQ(2), .QWID(1)) b2 ();
    fifo_drain_arbiter_if #(.WIDTH(8), .NQ(3), .QWID(2)) b3 ();

    fifo_drain_arbiter #(.WIDTH(8), .NQ(2), .QWID(1)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(b2));
    fifo_drain_arbiter #(.WIDTH(8), .NQ(3), .QWID(2)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(b3));

    typedef struct {
        logic        en;
        logic [1:0]  empty;
        logic [15:0] data;
        logic        rdy;
        logic [1:0]  pop;
        logic        ov;
        logic [7:0]  od;
        logic        qid;
        logic        dr;
    } vec_t;

    vec_t tv[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] q3 [3][2];
    int         rd [3];

    initial begin
        //           en  empty   data(q1,q0)  rdy  pop    ov   od     qid  dr
        tv[0]  = '{1'b0, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 2'b00, 16'hB0A0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 2'b00, 16'hB0A1, 1'b1, 2'b10, 1'b1, 8'hA0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 2'b00, 16'hB1A1, 1'b1, 2'b01, 1'b1, 8'hB0, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 2'b01, 16'hB100, 1'b1, 2'b10, 1'b1, 8'hA1, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b1, 8'hB1, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b0, 8'hB1, 1'b1, 1'b1};
        tv[7]  = '{1'b1, 2'b01, 16'hC000, 1'b1, 2'b10, 1'b0, 8'hB1, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 2'b01, 16'hC100, 1'b1, 2'b10, 1'b1, 8'hC0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 2'b01, 16'hC200, 1'b1, 2'b10, 1'b1, 8'hC1, 1'b1, 1'b0};
        tv[10] = '{1'b1, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b1, 8'hC2, 1'b1, 1'b0};
        tv[11] = '{1'b1, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b0, 8'hC2, 1'b1, 1'b1};
        tv[12] = '{1'b1, 2'b00, 16'hF0E0, 1'b1, 2'b01, 1'b0, 8'hC2, 1'b1, 1'b0};
        tv[13] = '{1'b1, 2'b00, 16'hF0E1, 1'b0, 2'b00, 1'b1, 8'hE0, 1'b0, 1'b0};
        tv[14] = '{1'b1, 2'b00, 16'hF0E1, 1'b0, 2'b00, 1'b1, 8'hE0, 1'b0, 1'b0};
        tv[15] = '{1'b1, 2'b00, 16'hF0E1, 1'b0, 2'b00, 1'b1, 8'hE0, 1'b0, 1'b0};
        tv[16] = '{1'b1, 2'b00, 16'hF0E1, 1'b1, 2'b10, 1'b1, 8'hE0, 1'b0, 1'b0};
        tv[17] = '{1'b1, 2'b10, 16'h00E1, 1'b0, 2'b00, 1'b1, 8'hF0, 1'b1, 1'b0};
        tv[18] = '{1'b0, 2'b10, 16'h00E1, 1'b1, 2'b00, 1'b1, 8'hF0, 1'b1, 1'b0};
        tv[19] = '{1'b0, 2'b10, 16'h00E1, 1'b1, 2'b00, 1'b0, 8'hF0, 1'b1, 1'b0};
        tv[20] = '{1'b0, 2'b00, 16'hF1E1, 1'b1, 2'b00, 1'b0, 8'hF0, 1'b1, 1'b0};
        tv[21] = '{1'b1, 2'b00, 16'hF1E1, 1'b1, 2'b01, 1'b0, 8'hF0, 1'b1, 1'b0};
        tv[22] = '{1'b1, 2'b00, 16'hF1E2, 1'b1, 2'b10, 1'b1, 8'hE1, 1'b0, 1'b0};
        tv[23] = '{1'b0, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b1, 8'hF1, 1'b1, 1'b0};
        tv[24] = '{1'b0, 2'b11, 16'h0000, 1'b1, 2'b00, 1'b0, 8'hF1, 1'b1, 1'b1};

        b2.enable = 1'b0; b2.empty = 2'b11; b2.fifo_data = '0; b2.out_ready = 1'b1;
        b3.enable = 1'b0; b3.empty = 3'b111; b3.fifo_data = '0; b3.out_ready = 1'b1;

        // Reset state while rst_n is held low.
        #7;
        chk("rst_out_valid", 32'(b2.out_valid), 32'd0);
        chk("rst_pop", 32'(b2.pop), 32'd0);
        chk("rst_out_data", 32'(b2.out_data), 32'd0);
        chk("rst_drained", 32'(b2.drained), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 25; v++) begin
            @(negedge clk);
            b2.enable    = tv[v].en;
            b2.empty     = tv[v].empty;
            b2.fifo_data = tv[v].data;
            b2.out_ready = tv[v].rdy;
            #1;
            chk($sformatf("v%0d_pop", v), 32'(b2.pop), 32'(tv[v].pop));
            chk($sformatf("v%0d_out_valid", v), 32'(b2.out_valid), 32'(tv[v].ov));
            chk($sformatf("v%0d_out_data", v), 32'(b2.out_data), 32'(tv[v].od));
            chk($sformatf("v%0d_out_qid", v), 32'(b2.out_qid), 32'(tv[v].qid));
            chk($sformatf("v%0d_drained", v), 32'(b2.drained), 32'(tv[v].dr));
        end

        // Asynchronous reset between edges mid-stream.
        @(negedge clk);
        b2.enable = 1'b1; b2.empty = 2'b00; b2.fifo_data = 16'h5B5A; b2.out_ready = 1'b1;
        #1;
        chk("ar_pop0", 32'(b2.pop), 32'd1);
        @(negedge clk);
        #1;
        chk("ar_pop1", 32'(b2.pop), 32'd2);
        chk("ar_data", 32'(b2.out_data), 32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(b2.out_valid), 32'd0);
        chk("ar_pop_low", 32'(b2.pop), 32'd0);
        chk("ar_out_data", 32'(b2.out_data), 32'd0);
        chk("ar_out_qid", 32'(b2.out_qid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_first_pop", 32'(b2.pop), 32'd1);
        @(negedge clk);
        b2.enable = 1'b0; b2.empty = 2'b11;
        #1;
        chk("ar_reload_data", 32'(b2.out_data), 32'h5A);

        // NQ=3: per-queue FIFO model, all queues non-empty, grant order with wrap.
        for (int i = 0; i < 3; i++) begin
            rd[i] = 0;
            for (int j = 0; j < 2; j++) q3[i][j] = 8'(8'h10 * (i + 1) + j);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b3.enable    = 1'b1;
            b3.out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                b3.empty[i] = (rd[i] >= 2);
                b3.fifo_data[i*8 +: 8] = (rd[i] < 2) ? q3[i][rd[i] % 2] : 8'h00;
            end
            #1;
            if (k < 6) chk($sformatf("q3_pop%0d", k), 32'(b3.pop), 32'(1 << (k % 3)));
            else       chk($sformatf("q3_pop%0d", k), 32'(b3.pop), 32'd0);
            if (k >= 1 && k <= 6) begin
                chk($sformatf("q3_ov%0d", k), 32'(b3.out_valid), 32'd1);
                chk($sformatf("q3_qid%0d", k), 32'(b3.out_qid), 32'((k - 1) % 3));
                chk($sformatf("q3_data%0d", k), 32'(b3.out_data),
                    32'(8'h10 * ((k - 1) % 3 + 1) + (k - 1) / 3));
            end
            if (k == 7) begin
                chk("q3_ov_end", 32'(b3.out_valid), 32'd0);
                chk("q3_drained", 32'(b3.drained), 32'd1);
            end
            for (int i = 0; i < 3; i++) if (b3.pop[i]) rd[i]++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
